// File: rtl/hansen_fetch_unit.sv
// Instruction-fetch front end: credit-limited request/grant port, in-order responses,
// DEPTH-entry {pc, instr} prefetch queue drained by decode, flush-and-drop on redirect.
module hansen_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic grant, rsp, push, pop;

  // Queue entries plus outstanding requests never exceed DEPTH, so every response has a slot.
  assign imem_req  = !reset && !redirect_valid &&
                     (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && (inflight_q != '0);
  assign push      = rsp && (drop_cnt_q == '0) && !redirect_valid;

  // Decode side: valid/ready, head transfers when out_valid && out_ready; a redirect voids it.
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = inflight_q - CW'(rsp);
      drop_cnt_d = inflight_q - CW'(rsp);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      inflight_d = inflight_q + CW'(grant) - CW'(rsp);
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + PC_STEP;
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_hansen_fetch_unit.sv
// Bench for hansen_fetch_unit: in-order memory model with variable latency, directed
// vector table, hand-written redirect/wrap/reset sequences and a PC-stream scoreboard.
module tb_hansen_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = 32'h0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  always #5 clk = ~clk;

  hansen_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          ov;
    logic [31:0] pc;
  } vec_t;

  pend_t       pend_q[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rv_en = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc = 32'h0;

  logic        s_req, s_ov;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [7:0]  s_drop, s_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at posedge+1, sample and score at negedge, return at next posedge+1.
  task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    imem_gnt       = gnt;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc && rv_en) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_ov    = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_drop  = 8'(dut.drop_cnt_q);
    s_count = 8'(dut.count_q);
    if (imem_req && imem_gnt) pend_q.push_back('{imem_addr, cyc + lat});
    if (redir) begin
      exp_pc = rpc;
    end else if (out_valid && out_ready) begin
      chk("sb_pc", out_pc, exp_pc);
      chk("sb_instr", out_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    chk("outstanding_le_depth", pend_q.size() <= DEPTH, 1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend_q.delete();
    exp_pc = 32'h0;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_req", s_req, 0);
    chk("rst_addr", s_addr, 32'h0);
    chk("rst_out_valid", s_ov, 0);
    chk("rst_out_pc", s_pc, 32'h0);
    chk("rst_out_instr", s_instr, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  // Runs with ready=1 until a head is consumed; expiry counts as a failure.
  task automatic wait_ov(input string name, input logic [31:0] want_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      seen = s_ov;
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) chk({name, "_pc"}, s_pc, want_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    // Fill with out_ready=0, then drain: gnt=1, latency 1.
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    tbl[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    tbl[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    // Streaming from reset: first out_valid two cycles after reset release.
    lat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_ov", s_ov, (k >= 2));
      if (k >= 2) begin
        chk("stream_pc", s_pc, 32'(4 * (k - 2)));
        chk("stream_instr", s_instr, mem_word(32'(4 * (k - 2))));
      end
    end

    // Table: backpressure fills the queue, then drains one per cycle.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, tbl[i].rdy, 1'b0, 32'h0);
      chk("tbl_req", s_req, tbl[i].req);
      chk("tbl_addr", s_addr, tbl[i].addr);
      chk("tbl_ov", s_ov, tbl[i].ov);
      if (tbl[i].ov) chk("tbl_pc", s_pc, tbl[i].pc);
      if (i == 5) chk("tbl_count_full", s_count, 8'd4);
    end

    // Redirect with two requests in flight (latency 3): both responses discarded.
    lat = 3;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    chk("redir_no_req", s_req, 0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_addr", s_addr, 32'h100);
    chk("redir_drop2", s_drop, 8'd2);
    wait_ov("redir_first", 32'h100);

    // Redirect coinciding with a response and a pop while two entries are queued.
    lat = 2;
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    chk("redir2_count_before", s_count, 8'd2);
    chk("redir2_no_req", s_req, 0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir2_flushed", s_ov, 0);
    chk("redir2_drop", s_drop, 8'd1);
    chk("redir2_addr", s_addr, 32'h200);
    wait_ov("redir2_first", 32'h200);

    // PC wrap at the top of the address space.
    lat = 1;
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    wait_ov("wrap0", 32'hFFFF_FFF8);
    wait_ov("wrap1", 32'hFFFF_FFFC);
    wait_ov("wrap2", 32'h0000_0000);

    // Random traffic scored against the sequential-PC reference.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          g, r, rd;
      logic [31:0] rpc;
      lat   = $urandom_range(1, 4);
      rv_en = ($urandom_range(0, 3) != 0);
      g     = ($urandom_range(0, 3) != 0);
      r     = ($urandom_range(0, 2) != 0);
      rd    = ($urandom_range(0, 39) == 0);
      rpc   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      cycle(g, r, rd, rpc);
    end
    rv_en = 1'b1;
    lat   = 1;

    // Reset in the middle of traffic restarts the stream at the reset PC.
    do_reset();
    wait_ov("post_reset", 32'h0);
    wait_ov("post_reset_next", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
